// File: rtl/gcd_pkg.sv
// Shared definitions for the binary (Stein) GCD engine: one-hot state
// encodings and the counter-width helper.
package gcd_pkg;

    typedef enum logic [3:0] {
        I    = 4'b0001,
        SUB  = 4'b0010,
        MULT = 4'b0100,
        DONE = 4'b1000
    } state_t;

    // Bits needed to count factors of two in a WIDTH-bit operand, plus one.
    function automatic int clog2_p1(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(value)) begin
                r = k + 1;
            end
        end
        return r + 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational reduction step of Stein's algorithm: swaps, subtracts or
// halves the working pair and reports the termination flags.
module gcd_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             inc_twos,
    output logic             eq,
    output logic             b_zero
);

    assign eq     = (a == b);
    assign b_zero = (b == '0);

    // Reduction rule selection; keeps A >= B so the odd-odd subtract never wraps.
    always_comb begin
        a_next   = a;
        b_next   = b;
        inc_twos = 1'b0;
        if (a < b) begin
            a_next = b;
            b_next = a;
        end else if (a[0] && b[0]) begin
            a_next = a - b;
        end else if (!a[0] && !b[0]) begin
            a_next   = a >> 1;
            b_next   = b >> 1;
            inc_twos = 1'b1;
        end else if (!a[0]) begin
            a_next = a >> 1;
        end else begin
            b_next = b >> 1;
        end
    end

endmodule

// File: rtl/gcd_stein_param.sv
// Parameterised binary GCD with one-hot FSM (I/SUB/MULT/DONE).
// Optional cycle counter output Cycles enabled by macro GCD_CYCLE_CNT_EN.
module gcd_stein_param
    import gcd_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = clog2_p1(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [CW-1:0]    i_count,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done,
    output logic             Busy
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [15:0]      Cycles
`endif
);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] gcd_r;
    logic [CW-1:0]    icnt_r;
    logic             busy_r;

    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic             inc_s;
    logic             eq_s;
    logic             b_zero_s;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_r),
        .b        (b_r),
        .a_next   (a_next_s),
        .b_next   (b_next_s),
        .inc_twos (inc_s),
        .eq       (eq_s),
        .b_zero   (b_zero_s)
    );

    // FSM and datapath registers; Busy is registered alongside the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= I;
            a_r     <= '0;
            b_r     <= '0;
            gcd_r   <= '0;
            icnt_r  <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                I: begin
                    a_r    <= Ain;
                    b_r    <= Bin;
                    icnt_r <= '0;
                    gcd_r  <= '0;
                    if (Start) begin
                        state_r <= SUB;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= I;
                        busy_r  <= 1'b0;
                    end
                end
                SUB: begin
                    if (CEN) begin
                        if (eq_s || b_zero_s) begin
                            gcd_r <= a_r;
                            if (icnt_r == '0) begin
                                state_r <= DONE;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= MULT;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            a_r <= a_next_s;
                            b_r <= b_next_s;
                            if (inc_s) begin
                                icnt_r <= icnt_r + CW'(1);
                            end
                        end
                    end
                end
                MULT: begin
                    if (CEN) begin
                        gcd_r  <= gcd_r << 1;
                        icnt_r <= icnt_r - CW'(1);
                        if (icnt_r == CW'(1)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    if (Ack) begin
                        state_r <= I;
                    end
                end
                default: begin
                    state_r <= I;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [15:0] cycles_r;

    // Saturating count of enabled SUB/MULT steps for the current run.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycles_r <= 16'd0;
        end else begin
            case (state_r)
                I: cycles_r <= 16'd0;
                SUB, MULT: begin
                    if (CEN && (cycles_r != 16'hFFFF)) begin
                        cycles_r <= cycles_r + 16'd1;
                    end
                end
                default: cycles_r <= cycles_r;
            endcase
        end
    end

    assign Cycles = cycles_r;
`endif

    assign A       = a_r;
    assign B       = b_r;
    assign AB_GCD  = gcd_r;
    assign i_count = icnt_r;
    assign q_I     = state_r[0];
    assign q_Sub   = state_r[1];
    assign q_Mult  = state_r[2];
    assign q_Done  = state_r[3];
    assign Busy    = busy_r;

endmodule
